// File: rtl/row_reg_loader_pkg.sv
// Shared conv package: datapath geometry, the row-segment descriptor
// exchanged with the row address generator, and the loader FSM states.
package row_reg_loader_pkg;

    localparam int PIXELS_IN_ROW = 32;
    localparam int PIX_W         = 8;

    typedef struct packed {
        logic [15:0] row_idx;
        logic [15:0] row_start_idx;
        logic [15:0] reg_start_idx;
        logic [15:0] reg_end_idx;
        logic [3:0]  west_pad;
        logic [3:0]  slab_num;
        logic [3:0]  east_pad;
        logic        last;
    } row_seg_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_WAIT,
        ST_DATA,
        ST_EPAD
    } loader_state_t;

endpackage

// File: rtl/row_reg_loader_word_aligner.sv
// Combinational pixel aligner: selects an n-pixel run starting at pixel
// 'off' of the word pair {word1, word0} and places it on lanes 0..n-1.
module row_word_aligner #(
    parameter int PIXELS_IN_ROW = 32,
    parameter int PIX_W         = 8
) (
    input  logic [PIXELS_IN_ROW*PIX_W-1:0]     word0,
    input  logic [PIXELS_IN_ROW*PIX_W-1:0]     word1,
    input  logic [$clog2(PIXELS_IN_ROW)-1:0]   off,
    input  logic [$clog2(PIXELS_IN_ROW):0]     n,
    output logic [PIXELS_IN_ROW*PIX_W-1:0]     data,
    output logic [PIXELS_IN_ROW-1:0]           mask
);

    logic [2*PIXELS_IN_ROW*PIX_W-1:0] pair;

    assign pair = {word1, word0};

    // Lane i takes pixel off+i of the pair when inside the run, else zero.
    always_comb begin
        data = '0;
        mask = '0;
        for (int unsigned i = 0; i < PIXELS_IN_ROW; i++) begin
            if (i < 32'(n)) begin
                mask[i]                 = 1'b1;
                data[i*PIX_W +: PIX_W]  = pair[(32'(off) + i)*PIX_W +: PIX_W];
            end
        end
    end

endmodule

// File: rtl/row_reg_loader.sv
// Row register loader: consumes one row-segment descriptor at a time,
// fetches one or two row-buffer words, and writes west pad, aligned
// pixel data and east pad into the PE line register file.
module row_reg_loader #(
    parameter int PIXELS_IN_ROW = row_reg_loader_pkg::PIXELS_IN_ROW,
    parameter int PIX_W         = row_reg_loader_pkg::PIX_W,
    parameter int RD_LAT        = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [15:0]                    row_words,
    input  logic                           desc_valid,
    output logic                           desc_ready,
    input  logic [15:0]                    desc_row_idx,
    input  logic [15:0]                    desc_row_start_idx,
    input  logic [15:0]                    desc_reg_start_idx,
    input  logic [15:0]                    desc_reg_end_idx,
    input  logic [3:0]                     desc_west_pad,
    input  logic [3:0]                     desc_slab_num,
    input  logic [3:0]                     desc_east_pad,
    input  logic                           desc_last,
    output logic                           buf_rd_en,
    output logic [15:0]                    buf_rd_addr,
    input  logic [PIXELS_IN_ROW*PIX_W-1:0] buf_rd_data,
    output logic                           rf_wr_en,
    output logic [15:0]                    rf_wr_base,
    output logic [PIXELS_IN_ROW-1:0]       rf_wr_mask,
    output logic [PIXELS_IN_ROW*PIX_W-1:0] rf_wr_data,
    output logic                           seg_done,
    output logic                           row_done,
    output logic                           busy
);

    import row_reg_loader_pkg::*;

    localparam int OFF_W = $clog2(PIXELS_IN_ROW);
    localparam int DW    = PIXELS_IN_ROW*PIX_W;

    loader_state_t state, state_d;

    row_seg_desc_t desc_in, desc_q;
    logic          accept;

    logic [15:0]      n_d, addr0_d, addr0_q;
    logic [OFF_W-1:0] off_d, off_q;
    logic [OFF_W:0]   n_q;
    logic [16:0]      run_end_d;
    logic             span_d, span_q;

    logic [RD_LAT-1:0] vld_pipe, tag_pipe;
    logic              rd_hi, ret_vld, ret_hi;

    logic [DW-1:0]            lo_q, hi_q, aln_data;
    logic [PIXELS_IN_ROW-1:0] aln_mask;
    logic [15:0]              west_base, east_base;

    function automatic logic [PIXELS_IN_ROW-1:0] low_mask(input logic [3:0] cnt);
        logic [PIXELS_IN_ROW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < PIXELS_IN_ROW; i++) begin
            m[i] = (i < 32'(cnt));
        end
        return m;
    endfunction

    assign desc_in = '{row_idx:       desc_row_idx,
                       row_start_idx: desc_row_start_idx,
                       reg_start_idx: desc_reg_start_idx,
                       reg_end_idx:   desc_reg_end_idx,
                       west_pad:      desc_west_pad,
                       slab_num:      desc_slab_num,
                       east_pad:      desc_east_pad,
                       last:          desc_last};

    assign accept    = desc_valid & desc_ready;
    assign n_d       = desc_in.reg_end_idx - 16'(desc_in.east_pad) - desc_in.reg_start_idx + 16'd1;
    assign off_d     = desc_in.row_start_idx[OFF_W-1:0];
    assign addr0_d   = desc_in.row_idx * row_words + (desc_in.row_start_idx >> OFF_W);
    assign run_end_d = 17'(off_d) + 17'(n_d);
    assign span_d    = run_end_d > 17'(PIXELS_IN_ROW);

    assign west_base = desc_q.reg_start_idx - 16'(desc_q.slab_num) - 16'(desc_q.west_pad);
    assign east_base = desc_q.reg_end_idx - 16'(desc_q.east_pad) + 16'd1;

    assign ret_vld = vld_pipe[RD_LAT-1];
    assign ret_hi  = tag_pipe[RD_LAT-1];

    // Latch the accepted descriptor together with its derived read geometry.
    always_ff @(posedge clk) begin
        if (reset) begin
            desc_q  <= '0;
            addr0_q <= '0;
            off_q   <= '0;
            n_q     <= '0;
            span_q  <= 1'b0;
        end else if (accept) begin
            desc_q  <= desc_in;
            addr0_q <= addr0_d;
            off_q   <= off_d;
            n_q     <= n_d[OFF_W:0];
            span_q  <= span_d;
        end
    end

    // Read-return tagging: valid marks a returning word, tag marks it as word1.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= RD_LAT'({vld_pipe, buf_rd_en});
            tag_pipe <= RD_LAT'({tag_pipe, rd_hi});
        end
    end

    // Capture returning words into the lo/hi holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q <= '0;
            hi_q <= '0;
        end else if (ret_vld) begin
            if (ret_hi) hi_q <= buf_rd_data;
            else        lo_q <= buf_rd_data;
        end
    end

    row_word_aligner #(
        .PIXELS_IN_ROW (PIXELS_IN_ROW),
        .PIX_W         (PIX_W)
    ) u_aligner (
        .word0 (lo_q),
        .word1 (hi_q),
        .off   (off_q),
        .n     (n_q),
        .data  (aln_data),
        .mask  (aln_mask)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Next state and all outputs; every output is held at zero while in reset.
    always_comb begin
        state_d     = state;
        desc_ready  = 1'b0;
        buf_rd_en   = 1'b0;
        buf_rd_addr = '0;
        rd_hi       = 1'b0;
        rf_wr_en    = 1'b0;
        rf_wr_base  = '0;
        rf_wr_mask  = '0;
        rf_wr_data  = '0;
        seg_done    = 1'b0;
        row_done    = 1'b0;
        busy        = 1'b0;
        if (!reset) begin
            busy = (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    desc_ready = 1'b1;
                    if (desc_valid) state_d = ST_RD0;
                end
                ST_RD0: begin
                    buf_rd_en   = 1'b1;
                    buf_rd_addr = addr0_q;
                    if (desc_q.west_pad != 4'd0) begin
                        rf_wr_en   = 1'b1;
                        rf_wr_base = west_base;
                        rf_wr_mask = low_mask(desc_q.west_pad);
                    end
                    state_d = span_q ? ST_RD1 : ST_WAIT;
                end
                ST_RD1: begin
                    buf_rd_en   = 1'b1;
                    buf_rd_addr = addr0_q + 16'd1;
                    rd_hi       = 1'b1;
                    state_d     = ST_WAIT;
                end
                ST_WAIT: begin
                    // The last expected word is word1 for a spanning run, word0 otherwise.
                    if (ret_vld && (ret_hi == span_q)) state_d = ST_DATA;
                end
                ST_DATA: begin
                    rf_wr_en   = 1'b1;
                    rf_wr_base = desc_q.reg_start_idx;
                    rf_wr_mask = aln_mask;
                    rf_wr_data = aln_data;
                    if (desc_q.east_pad != 4'd0) begin
                        state_d = ST_EPAD;
                    end else begin
                        seg_done = 1'b1;
                        row_done = desc_q.last;
                        state_d  = ST_IDLE;
                    end
                end
                ST_EPAD: begin
                    rf_wr_en   = 1'b1;
                    rf_wr_base = east_base;
                    rf_wr_mask = low_mask(desc_q.east_pad);
                    seg_done   = 1'b1;
                    row_done   = desc_q.last;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_row_reg_loader.sv
// Bench for row_reg_loader: row-buffer responder, per-cycle reference
// schedule derived from descriptor fields, and directed descriptors with
// hand-computed pins.
module tb_row_reg_loader;

    localparam int P      = 32;
    localparam int W      = 8;
    localparam int DW     = P*W;
    localparam int RD_LAT = 2;
    localparam int MAXC   = 600;

    localparam int L_RD   = 0;
    localparam int L_BASE = 1;
    localparam int L_MASK = 2;
    localparam int L_SEG  = 3;
    localparam int L_ROW  = 4;
    localparam int L_LANE = 5;
    localparam int L_RDY  = 6;
    localparam int L_WREN = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   row_words;
    logic          desc_valid;
    logic          desc_ready;
    logic [15:0]   desc_row_idx, desc_row_start_idx, desc_reg_start_idx, desc_reg_end_idx;
    logic [3:0]    desc_west_pad, desc_slab_num, desc_east_pad;
    logic          desc_last;
    logic          buf_rd_en;
    logic [15:0]   buf_rd_addr;
    logic [DW-1:0] buf_rd_data;
    logic          rf_wr_en;
    logic [15:0]   rf_wr_base;
    logic [P-1:0]  rf_wr_mask;
    logic [DW-1:0] rf_wr_data;
    logic          seg_done, row_done, busy;

    row_reg_loader #(
        .PIXELS_IN_ROW (P),
        .PIX_W         (W),
        .RD_LAT        (RD_LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .row_words          (row_words),
        .desc_valid         (desc_valid),
        .desc_ready         (desc_ready),
        .desc_row_idx       (desc_row_idx),
        .desc_row_start_idx (desc_row_start_idx),
        .desc_reg_start_idx (desc_reg_start_idx),
        .desc_reg_end_idx   (desc_reg_end_idx),
        .desc_west_pad      (desc_west_pad),
        .desc_slab_num      (desc_slab_num),
        .desc_east_pad      (desc_east_pad),
        .desc_last          (desc_last),
        .buf_rd_en          (buf_rd_en),
        .buf_rd_addr        (buf_rd_addr),
        .buf_rd_data        (buf_rd_data),
        .rf_wr_en           (rf_wr_en),
        .rf_wr_base         (rf_wr_base),
        .rf_wr_mask         (rf_wr_mask),
        .rf_wr_data         (rf_wr_data),
        .seg_done           (seg_done),
        .row_done           (row_done),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel content of the row buffer: word address a, lane l.
    function automatic logic [W-1:0] pix(input logic [15:0] a, input int unsigned l);
        return W'((32'(a)*37 + l*5 + 11) % 256);
    endfunction

    function automatic logic [DW-1:0] word_at(input logic [15:0] a);
        logic [DW-1:0] w;
        for (int unsigned l = 0; l < P; l++) w[l*W +: W] = pix(a, l);
        return w;
    endfunction

    // Row buffer: data appears exactly RD_LAT cycles after the read strobe.
    logic [RD_LAT-1:0] rsp_en = '0;
    logic [15:0]       rsp_addr [RD_LAT];
    always @(posedge clk) begin
        rsp_en      <= RD_LAT'({rsp_en, buf_rd_en});
        rsp_addr[0] <= buf_rd_addr;
        for (int i = 1; i < RD_LAT; i++) rsp_addr[i] <= rsp_addr[i-1];
    end
    assign buf_rd_data = rsp_en[RD_LAT-1] ? word_at(rsp_addr[RD_LAT-1]) : {(DW/8){8'hA5}};

    typedef struct packed {
        logic          ready;
        logic          busy;
        logic          rd_en;
        logic [15:0]   rd_addr;
        logic          wr_en;
        logic [15:0]   wr_base;
        logic [P-1:0]  wr_mask;
        logic [DW-1:0] wr_data;
        logic          seg;
        logic          row;
    } obs_t;

    typedef struct {
        int            cyc;
        int            kind;
        int            lane;
        logic [DW-1:0] val;
    } lit_t;

    obs_t exp_tab [MAXC];
    lit_t lit_tab [64];
    int   lit_n = 0;
    int   acc_cnt = 0;
    int   acc_cyc = 0;
    logic slab_watch = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic logic [P-1:0] low_bits(input logic [3:0] c);
        logic [P-1:0] m;
        m = '0;
        for (int i = 0; i < int'(c); i++) m[i] = 1'b1;
        return m;
    endfunction

    // Expected cycle-by-cycle behaviour for a descriptor accepted in cycle t.
    task automatic schedule(input int t);
        logic [15:0] nn16, base_word, g, wa;
        int          nn, off, d, f;
        logic        span;
        obs_t        o;
        nn16      = desc_reg_end_idx - 16'(desc_east_pad) - desc_reg_start_idx + 16'd1;
        nn        = int'(nn16);
        off       = int'(desc_row_start_idx) % P;
        span      = (off + nn) > P;
        base_word = 16'(32'(desc_row_idx)*32'(row_words) + 32'(desc_row_start_idx)/P);
        d = t + 2 + RD_LAT + (span ? 1 : 0);
        f = (desc_east_pad != 4'd0) ? d + 1 : d;
        for (int k = t + 1; k <= f; k++) begin
            exp_tab[k].ready = 1'b0;
            exp_tab[k].busy  = 1'b1;
        end
        o = exp_tab[t+1];
        o.rd_en   = 1'b1;
        o.rd_addr = base_word;
        if (desc_west_pad != 4'd0) begin
            o.wr_en   = 1'b1;
            o.wr_base = desc_reg_start_idx - 16'(desc_slab_num) - 16'(desc_west_pad);
            o.wr_mask = low_bits(desc_west_pad);
        end
        exp_tab[t+1] = o;
        if (span) begin
            o = exp_tab[t+2];
            o.rd_en   = 1'b1;
            o.rd_addr = base_word + 16'd1;
            exp_tab[t+2] = o;
        end
        o = exp_tab[d];
        o.wr_en   = 1'b1;
        o.wr_base = desc_reg_start_idx;
        for (int k = 0; k < nn; k++) begin
            g  = desc_row_start_idx + 16'(k);
            wa = 16'(32'(desc_row_idx)*32'(row_words) + 32'(g)/P);
            o.wr_mask[k]         = 1'b1;
            o.wr_data[k*W +: W]  = pix(wa, 32'(g) % P);
        end
        exp_tab[d] = o;
        if (desc_east_pad != 4'd0) begin
            o = exp_tab[f];
            o.wr_en   = 1'b1;
            o.wr_base = desc_reg_end_idx - 16'(desc_east_pad) + 16'd1;
            o.wr_mask = low_bits(desc_east_pad);
            exp_tab[f] = o;
        end
        exp_tab[f].seg = 1'b1;
        exp_tab[f].row = desc_last;
    endtask

    // Model update and per-cycle comparison, sampled mid-cycle.
    initial begin
        obs_t        e, a;
        logic [DW+16:0] got, want;
        string       nm;
        logic        hit;
        logic [15:0] r;
        for (int k = 0; k < MAXC; k++) exp_tab[k] = idle_obs();
        forever begin
            @(negedge clk);
            if (cyc + 40 >= MAXC) begin
                $display("FAIL model-range: cycle %0d exceeds table %0d", cyc, MAXC);
                $fatal(1);
            end
            if (reset) begin
                exp_tab[cyc] = '0;
                for (int k = cyc + 1; k < cyc + 30; k++) exp_tab[k] = idle_obs();
            end else if (desc_valid && exp_tab[cyc].ready) begin
                schedule(cyc);
                acc_cnt = acc_cnt + 1;
                acc_cyc = cyc;
            end
            e = exp_tab[cyc];
            a.ready   = desc_ready;
            a.busy    = busy;
            a.rd_en   = buf_rd_en;
            a.rd_addr = buf_rd_addr;
            a.wr_en   = rf_wr_en;
            a.wr_base = rf_wr_base;
            a.wr_mask = rf_wr_mask;
            a.wr_data = rf_wr_data;
            a.seg     = seg_done;
            a.row     = row_done;
            if (!reset) begin
                if (!e.rd_en) begin
                    e.rd_addr = '0; a.rd_addr = '0;
                end
                if (!e.wr_en) begin
                    e.wr_base = '0; a.wr_base = '0;
                    e.wr_mask = '0; a.wr_mask = '0;
                    e.wr_data = '0; a.wr_data = '0;
                end
            end
            checks = checks + 1;
            if (a !== e) begin
                fails = fails + 1;
                $display("FAIL cycle %0d outputs: got rdy=%b busy=%b rd=%b/%h wr=%b/%h/%h seg=%b row=%b data=%h | want rdy=%b busy=%b rd=%b/%h wr=%b/%h/%h seg=%b row=%b data=%h",
                         cyc, a.ready, a.busy, a.rd_en, a.rd_addr, a.wr_en, a.wr_base, a.wr_mask, a.seg, a.row, a.wr_data,
                         e.ready, e.busy, e.rd_en, e.rd_addr, e.wr_en, e.wr_base, e.wr_mask, e.seg, e.row, e.wr_data);
            end
            for (int i = 0; i < lit_n; i++) begin
                if (lit_tab[i].cyc == cyc) begin
                    got = '0; want = '0; nm = "";
                    case (lit_tab[i].kind)
                        L_RD:   begin nm = "rd_addr"; got = {buf_rd_en, buf_rd_addr}; want = {1'b1, lit_tab[i].val[15:0]}; end
                        L_BASE: begin nm = "wr_base"; got = {rf_wr_en, rf_wr_base};  want = {1'b1, lit_tab[i].val[15:0]}; end
                        L_MASK: begin nm = "wr_mask"; got = {rf_wr_en, rf_wr_mask};  want = {1'b1, lit_tab[i].val[P-1:0]}; end
                        L_SEG:  begin nm = "seg_done";   got = (DW+17)'(seg_done);   want = (DW+17)'(lit_tab[i].val[0]); end
                        L_ROW:  begin nm = "row_done";   got = (DW+17)'(row_done);   want = (DW+17)'(lit_tab[i].val[0]); end
                        L_RDY:  begin nm = "desc_ready"; got = (DW+17)'(desc_ready); want = (DW+17)'(lit_tab[i].val[0]); end
                        L_WREN: begin nm = "rf_wr_en";   got = (DW+17)'(rf_wr_en);   want = (DW+17)'(lit_tab[i].val[0]); end
                        default: begin
                            nm   = "lane_pixel";
                            got  = {rf_wr_en, rf_wr_data[lit_tab[i].lane*W +: W]};
                            want = {1'b1, lit_tab[i].val[W-1:0]};
                        end
                    endcase
                    checks = checks + 1;
                    if (got !== want) begin
                        fails = fails + 1;
                        $display("FAIL pin %s (lane %0d) cycle %0d: got %h want %h", nm, lit_tab[i].lane, cyc, got, want);
                    end
                end
            end
            if (slab_watch && rf_wr_en) begin
                hit = 1'b0;
                for (int i = 0; i < P; i++) begin
                    r = rf_wr_base + 16'(i);
                    if (rf_wr_mask[i] && r >= 16'd2 && r <= 16'd4) hit = 1'b1;
                end
                checks = checks + 1;
                if (hit) begin
                    fails = fails + 1;
                    $display("FAIL slab_untouched cycle %0d: base %h mask %h writes a slab register", cyc, rf_wr_base, rf_wr_mask);
                end
            end
        end
    end

    task automatic pin(input int c, input int k, input int lane, input logic [DW-1:0] v);
        lit_tab[lit_n] = '{cyc: c, kind: k, lane: lane, val: v};
        lit_n = lit_n + 1;
    endtask

    task automatic set_desc(input logic [15:0] ri, input logic [15:0] rs, input logic [15:0] gs,
                            input logic [15:0] ge, input logic [3:0] w, input logic [3:0] s,
                            input logic [3:0] e, input logic l);
        desc_row_idx       = ri;
        desc_row_start_idx = rs;
        desc_reg_start_idx = gs;
        desc_reg_end_idx   = ge;
        desc_west_pad      = w;
        desc_slab_num      = s;
        desc_east_pad      = e;
        desc_last          = l;
    endtask

    // Returns #1 after the edge that ends the accept cycle; t is that cycle.
    task automatic wait_acc(output int t);
        int start;
        int k;
        start = acc_cnt;
        k = 0;
        while (acc_cnt == start) begin
            @(posedge clk);
            k++;
            if (k > 40) begin
                $display("FAIL accept_timeout: no accept after %0d cycles", k);
                $fatal(1);
            end
        end
        #1;
        t = acc_cyc;
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int t, t2;
        reset      = 1'b1;
        row_words  = 16'd4;
        desc_valid = 1'b0;
        set_desc(16'd0, 16'd0, 16'd0, 16'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Aligned full run with west pad.
        set_desc(16'd2, 16'd0, 16'd3, 16'd34, 4'd2, 4'd0, 4'd0, 1'b0);
        desc_valid = 1'b1;
        wait_acc(t);
        desc_valid = 1'b0;
        pin(t+1, L_RD,   0, 8);
        pin(t+1, L_BASE, 0, 1);
        pin(t+1, L_MASK, 0, 'h3);
        pin(t+4, L_BASE, 0, 3);
        pin(t+4, L_MASK, 0, 'hFFFF_FFFF);
        pin(t+4, L_SEG,  0, 1);
        settle();

        // Run spanning two buffer words.
        set_desc(16'd0, 16'd40, 16'd1, 16'd32, 4'd0, 4'd0, 4'd0, 1'b0);
        desc_valid = 1'b1;
        wait_acc(t);
        desc_valid = 1'b0;
        pin(t+1, L_RD,   0,  1);
        pin(t+2, L_RD,   0,  2);
        pin(t+5, L_LANE, 0,  'h58);
        pin(t+5, L_LANE, 24, 'h55);
        pin(t+5, L_SEG,  0,  1);
        pin(t+4, L_WREN, 0,  0);
        settle();

        // Short run with east pad, last segment of the row.
        set_desc(16'd1, 16'd96, 16'd10, 16'd16, 4'd0, 4'd0, 4'd2, 1'b1);
        desc_valid = 1'b1;
        wait_acc(t);
        desc_valid = 1'b0;
        pin(t+1, L_RD,   0, 7);
        pin(t+4, L_BASE, 0, 10);
        pin(t+4, L_MASK, 0, 'h1F);
        pin(t+4, L_SEG,  0, 0);
        pin(t+5, L_BASE, 0, 15);
        pin(t+5, L_MASK, 0, 'h3);
        pin(t+5, L_SEG,  0, 1);
        pin(t+5, L_ROW,  0, 1);
        settle();

        // West pad with slab overlap registers 2..4 left alone.
        slab_watch = 1'b1;
        set_desc(16'd3, 16'd5, 16'd5, 16'd20, 4'd1, 4'd3, 4'd0, 1'b0);
        desc_valid = 1'b1;
        wait_acc(t);
        desc_valid = 1'b0;
        pin(t+1, L_BASE, 0, 1);
        pin(t+1, L_MASK, 0, 'h1);
        pin(t+4, L_BASE, 0, 5);
        pin(t+4, L_MASK, 0, 'hFFFF);
        settle();
        slab_watch = 1'b0;

        // Back-to-back descriptors with desc_valid held.
        set_desc(16'd1, 16'd0, 16'd0, 16'd31, 4'd0, 4'd0, 4'd0, 1'b0);
        desc_valid = 1'b1;
        wait_acc(t);
        set_desc(16'd0, 16'd17, 16'd100, 16'd103, 4'd1, 4'd0, 4'd1, 1'b1);
        pin(t+1, L_RD,  0, 4);
        pin(t+4, L_SEG, 0, 1);
        pin(t+4, L_RDY, 0, 0);
        pin(t+5, L_RDY, 0, 1);
        wait_acc(t2);
        desc_valid = 1'b0;
        pin(t2+1, L_RD,   0, 0);
        pin(t2+1, L_BASE, 0, 99);
        pin(t2+4, L_BASE, 0, 100);
        pin(t2+4, L_MASK, 0, 'h7);
        pin(t2+5, L_BASE, 0, 103);
        pin(t2+5, L_ROW,  0, 1);
        settle();

        // Reset two cycles into a spanning descriptor.
        set_desc(16'd3, 16'd31, 16'd0, 16'd1, 4'd0, 4'd0, 4'd0, 1'b0);
        desc_valid = 1'b1;
        wait_acc(t);
        desc_valid = 1'b0;
        pin(t+1, L_RD,  0, 12);
        pin(t+2, L_RDY, 0, 0);
        pin(t+3, L_RDY, 0, 1);
        for (int k = 3; k <= 7; k++) begin
            pin(t+k, L_WREN, 0, 0);
            pin(t+k, L_SEG,  0, 0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        settle();

        // Run ending exactly at the word boundary, all pads, wrapped west base.
        set_desc(16'd5, 16'd200, 16'd0, 16'd27, 4'd3, 4'd2, 4'd4, 1'b0);
        desc_valid = 1'b1;
        wait_acc(t);
        desc_valid = 1'b0;
        pin(t+1, L_RD,   0, 26);
        pin(t+1, L_BASE, 0, 'hFFFB);
        pin(t+1, L_MASK, 0, 'h7);
        pin(t+4, L_MASK, 0, 'h00FF_FFFF);
        pin(t+5, L_BASE, 0, 24);
        pin(t+5, L_MASK, 0, 'hF);
        pin(t+5, L_SEG,  0, 1);
        settle();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
